// File: rtl/timer_bcd_countdown.sv
// timer_bcd_countdown
//   MM:SS countdown timer core. Holds a loadable preset and counts it down
//   once per timer second while running, presenting four BCD digits for
//   downstream seven-segment decoders.
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high (also clears the preset)
//   load       1-cycle pulse: capture set_* (clamped to BCD) into preset/digits
//   set_mt     preset minutes tens
//   set_mo     preset minutes ones
//   set_st     preset seconds tens
//   set_so     preset seconds ones
//   start_stop 1-cycle pulse: run/pause toggle
//   clear      1-cycle pulse: restore preset, return to IDLE
//   min_tens   BCD digit, minutes tens
//   min_ones   BCD digit, minutes ones
//   sec_tens   BCD digit, seconds tens (0..5)
//   sec_ones   BCD digit, seconds ones
//   running    high while counting
//   done       high once the count has reached 00:00
module timer_bcd_countdown #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] set_mt,
  input  logic [3:0] set_mo,
  input  logic [3:0] set_st,
  input  logic [3:0] set_so,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [3:0]    pre_mt, pre_mo, pre_st, pre_so;

  logic [3:0] clamp_mt, clamp_mo, clamp_st, clamp_so;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       digits_zero, dec_zero;

  // Out-of-range settings saturate to the largest legal digit so the
  // display never shows a non-BCD value.
  always_comb begin
    clamp_mt = (set_mt > 4'd9) ? 4'd9 : set_mt;
    clamp_mo = (set_mo > 4'd9) ? 4'd9 : set_mo;
    clamp_st = (set_st > 4'd5) ? 4'd5 : set_st;
    clamp_so = (set_so > 4'd9) ? 4'd9 : set_so;
  end

  // One-second decrement with borrow rippling from seconds ones upward.
  // Seconds tens wraps to 5, the others to 9.
  always_comb begin
    dec_so = sec_ones - 4'd1;
    dec_st = sec_tens;
    dec_mo = min_ones;
    dec_mt = min_tens;
    if (sec_ones == 4'd0) begin
      dec_so = 4'd9;
      dec_st = sec_tens - 4'd1;
      if (sec_tens == 4'd0) begin
        dec_st = 4'd5;
        dec_mo = min_ones - 4'd1;
        if (min_ones == 4'd0) begin
          dec_mo = 4'd9;
          dec_mt = min_tens - 4'd1;
        end
      end
    end
  end

  assign digits_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign dec_zero    = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
                       (dec_st == 4'd0) && (dec_so == 4'd0);

  // Control FSM. Priority: rst > clear > load > start_stop > tick.
  // A load in RUN is ignored entirely, so lower-priority events still apply.
  // Pausing keeps the prescaler so a resume continues mid-second; only a
  // start from IDLE restarts the second from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prescaler <= '0;
      pre_mt    <= 4'd0;
      pre_mo    <= 4'd0;
      pre_st    <= 4'd0;
      pre_so    <= 4'd0;
      min_tens  <= 4'd0;
      min_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else if (clear) begin
      min_tens  <= pre_mt;
      min_ones  <= pre_mo;
      sec_tens  <= pre_st;
      sec_ones  <= pre_so;
      prescaler <= '0;
      state     <= IDLE;
      running   <= 1'b0;
      done      <= 1'b0;
    end else if (load && state != RUN) begin
      pre_mt    <= clamp_mt;
      pre_mo    <= clamp_mo;
      pre_st    <= clamp_st;
      pre_so    <= clamp_so;
      min_tens  <= clamp_mt;
      min_ones  <= clamp_mo;
      sec_tens  <= clamp_st;
      sec_ones  <= clamp_so;
      prescaler <= '0;
      state     <= IDLE;
      running   <= 1'b0;
      done      <= 1'b0;
    end else if (start_stop) begin
      case (state)
        IDLE: begin
          if (!digits_zero) begin
            prescaler <= '0;
            state     <= RUN;
            running   <= 1'b1;
          end
        end
        PAUSE: begin
          if (!digits_zero) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          state   <= PAUSE;
          running <= 1'b0;
        end
        default: ;
      endcase
    end else if (state == RUN) begin
      if (prescaler == TICK_LAST) begin
        prescaler <= '0;
        min_tens  <= dec_mt;
        min_ones  <= dec_mo;
        sec_tens  <= dec_st;
        sec_ones  <= dec_so;
        if (dec_zero) begin
          state   <= DONE;
          running <= 1'b0;
          done    <= 1'b1;
        end
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

endmodule
